demux_1to8_deser: RTL and testbench

- Sequential inverse of the team's 8:1 bit-select mux. It takes a serial bit stream and routes each accepted bit into slot A[sel], where sel is an internal 3-bit slot counter.
- Each completed 8-bit word is presented on a valid/ready output.
- Sits on the receive side of any link whose transmit side drives the 8:1 mux with an incrementing select, so bit i of the word travels in slot i, LSB first.

---
 rtl/demux_deser_pkg.sv | 16 +
 rtl/demux_1tox.sv | 27 ++
 rtl/demux_1to8_deser.sv | 102 ++++++++++
 tb/tb_demux_1to8_deser.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_deser_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserializer.
package demux_deser_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      STALL = 1'b1
   } state_t;

   localparam int N_DEF = 8;

   // A counter always needs at least one bit, even when N is degenerate.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/demux_1tox.sv
// Combinational 1-to-N decoder: routes one bit to slot sel and flags that slot
// with a one-hot write enable. Structural mirror of the N:1 bit-select mux.
module demux_1tox
   import demux_deser_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int SEL_W = sel_w(N)
) (
   input  logic             din,
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [N-1:0]     we,
   output logic [N-1:0]     dout
);

   always_comb begin
      we   = '0;
      dout = '0;
      for (int i = 0; i < N; i++) begin
         if (en && (sel == SEL_W'(i))) begin
            we[i]   = 1'b1;
            dout[i] = din;
         end
      end
   end

endmodule

// File: rtl/demux_1to8_deser.sv
// Serial-to-parallel deserializer: each accepted bit lands in slot sel, and a
// completed word is offered on a valid/ready output.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   FILL  | accepting bits; the output slot can absorb the next word
//   STALL | sel is at the last slot and the held word is not yet taken
module demux_1to8_deser
   import demux_deser_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int SEL_W = sel_w(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             frame_sync,
   output logic [SEL_W-1:0] sel,
   output logic [N-1:0]     out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_err
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

   state_t           state_q, state_d;
   logic [N-1:0]     asm_q;
   logic [N-1:0]     we, wdata;
   logic             acc, sync_take, consume, complete;
   logic [SEL_W-1:0] wr_sel;

   assign din_ready = ~((sel == LAST) & out_valid & ~out_ready);
   assign acc       = din_valid & din_ready;
   // A frame_sync held off by backpressure is ignored; without data it still realigns.
   assign sync_take = frame_sync & (acc | ~din_valid);
   assign wr_sel    = sync_take ? '0 : sel;
   assign complete  = acc & (wr_sel == LAST);
   assign consume   = out_valid & out_ready;

   demux_1tox #(.N(N), .SEL_W(SEL_W)) u_dec (
      .din  (din),
      .sel  (wr_sel),
      .en   (acc),
      .we   (we),
      .dout (wdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL: begin
            if ((sel == LAST) && out_valid && !out_ready && !sync_take) begin
               state_d = STALL;
            end
         end
         STALL: begin
            if (consume || sync_take) begin
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel       <= '0;
         asm_q     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         asm_q     <= (asm_q & ~we) | wdata;
         frame_err <= sync_take & (sel != '0);

         if (sync_take) begin
            sel <= acc ? SEL_W'(1) : '0;
         end else if (acc) begin
            sel <= sel + SEL_W'(1);
         end

         if (complete) begin
            out_data  <= {din, asm_q[N-2:0]};
            out_valid <= 1'b1;
         end else if (consume) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_demux_1to8_deser.sv
// Directed bench for the 1-to-8 deserializer: single word, streaming,
// backpressure, resynchronisation and mid-word reset.
module tb_demux_1to8_deser;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       din_ready;
   logic       frame_sync = 1'b0;
   logic [2:0] sel;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       frame_err;

   int n_vec = 0;
   int n_err = 0;

   demux_1to8_deser dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .frame_sync (frame_sync),
      .sel        (sel),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic d, input logic fs);
      din_valid  = v;
      din        = d;
      frame_sync = fs;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      out_ready = 1'b0;
      tick();
      n_vec++; if (sel !== 3'd0) begin n_err++; $display("FAIL reset_sel got %0d want 0", sel); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h want 00", out_data); end
      n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
      n_vec++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL reset_din_ready got %b want 1", din_ready); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_word();
      logic [7:0] w;
      w = 8'hA5;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, w[i], i == 0);
         tick();
         n_vec++; if (out_valid !== (i == 7)) begin n_err++; $display("FAIL single_valid bit %0d got %b want %b", i, out_valid, (i == 7)); end
         n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL single_frame_err bit %0d got %b want 0", i, frame_err); end
      end
      n_vec++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL single_data got %h want a5", out_data); end
      drive(1'b0, 1'b0, 1'b0);
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drop got %b want 0", out_valid); end
      n_vec++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL single_data_hold got %h want a5", out_data); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] s;
      s = 16'hF03C;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, s[i], (i % 8) == 0);
         #1;
         n_vec++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL b2b_din_ready cycle %0d got %b want 1", i, din_ready); end
         tick();
         n_vec++; if (out_valid !== (i == 7 || i == 15)) begin n_err++; $display("FAIL b2b_valid cycle %0d got %b want %b", i, out_valid, (i == 7 || i == 15)); end
         if (i == 7) begin
            n_vec++; if (out_data !== 8'h3C) begin n_err++; $display("FAIL b2b_word0 got %h want 3c", out_data); end
         end
         if (i == 15) begin
            n_vec++; if (out_data !== 8'hF0) begin n_err++; $display("FAIL b2b_word1 got %h want f0", out_data); end
         end
      end
      drive(1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_backpressure();
      logic [7:0] a, b;
      a = 8'h11;
      b = 8'h22;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, a[i], i == 0);
         tick();
      end
      n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin n_err++; $display("FAIL bp_first got v=%b d=%h want v=1 d=11", out_valid, out_data); end
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, b[i], i == 0);
         #1;
         n_vec++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_fill bit %0d got %b want 1", i, din_ready); end
         tick();
      end
      drive(1'b1, b[7], 1'b0);
      #1;
      n_vec++; if (sel !== 3'd7) begin n_err++; $display("FAIL bp_sel got %0d want 7", sel); end
      n_vec++; if (din_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready got %b want 0", din_ready); end
      tick();
      n_vec++; if (out_data !== 8'h11 || sel !== 3'd7) begin n_err++; $display("FAIL bp_hold got d=%h sel=%0d want d=11 sel=7", out_data, sel); end
      out_ready = 1'b1;
      #1;
      n_vec++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", din_ready); end
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin n_err++; $display("FAIL bp_second got v=%b d=%h want v=1 d=22", out_valid, out_data); end
      n_vec++; if (sel !== 3'd0) begin n_err++; $display("FAIL bp_sel_wrap got %0d want 0", sel); end
      out_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin n_err++; $display("FAIL bp_second_hold got v=%b d=%h want v=1 d=22", out_valid, out_data); end
      out_ready = 1'b1;
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid); end
   endtask

   task automatic test_resync();
      logic [7:0] w;
      int         valids;
      int         errs;
      w = 8'h81;
      valids = 0;
      errs = 0;
      out_ready = 1'b1;
      // Realign with no data present: sel clears and the error still flags.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, i == 0);
         tick();
      end
      drive(1'b0, 1'b0, 1'b1);
      tick();
      n_vec++; if (sel !== 3'd0 || frame_err !== 1'b1) begin n_err++; $display("FAIL resync_nodata got sel=%0d err=%b want sel=0 err=1", sel, frame_err); end
      drive(1'b0, 1'b0, 1'b0);
      tick();
      n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL resync_nodata_pulse got %b want 0", frame_err); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, i == 0);
         tick();
         if (out_valid) valids++;
         if (frame_err) errs++;
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, w[i], i == 0);
         tick();
         if (i == 0) begin
            n_vec++; if (frame_err !== 1'b1 || sel !== 3'd1) begin n_err++; $display("FAIL resync_err got err=%b sel=%0d want err=1 sel=1", frame_err, sel); end
         end
         if (out_valid) valids++;
         if (frame_err) errs++;
      end
      n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h81) begin n_err++; $display("FAIL resync_word got v=%b d=%h want v=1 d=81", out_valid, out_data); end
      n_vec++; if (valids !== 1) begin n_err++; $display("FAIL resync_valid_count got %0d want 1", valids); end
      n_vec++; if (errs !== 1) begin n_err++; $display("FAIL resync_err_count got %0d want 1", errs); end
      drive(1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] a, b;
      a = 8'h5A;
      b = 8'h6E;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, a[i], i == 0);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, b[i] ^ 1'b1, i == 0);
         tick();
      end
      n_vec++; if (out_valid !== 1'b1 || sel !== 3'd5) begin n_err++; $display("FAIL rst_pre got v=%b sel=%0d want v=1 sel=5", out_valid, sel); end
      drive(1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (sel !== 3'd0) begin n_err++; $display("FAIL rst_mid_sel got %0d want 0", sel); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
      n_vec++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got %b want 1", din_ready); end
      n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_mid_data got %h want 00", out_data); end
      tick();
      rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, b[i], i == 0);
         tick();
         n_vec++; if (out_valid !== (i == 7)) begin n_err++; $display("FAIL rst_after_valid bit %0d got %b want %b", i, out_valid, (i == 7)); end
      end
      n_vec++; if (out_data !== 8'h6E || frame_err !== 1'b0) begin n_err++; $display("FAIL rst_after_word got d=%h err=%b want d=6e err=0", out_data, frame_err); end
      drive(1'b0, 1'b0, 1'b0);
      tick();
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_resync();
      test_reset_mid_word();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
